// File: rtl/alu_exec_stage.sv
// alu_exec_stage -- handshaked execute stage.
//
// Takes a decoded ALU op plus two operands and returns a registered result
// with zero / branch-taken / illegal flags. Plain ALU ops load the output
// registers on the accept edge; MUL (optional) runs a shift-add loop for
// WIDTH cycles before loading them.
//
// Build option:
//   ALU_EXEC_MUL_EN  defined   -> op 12 is an iterative WIDTH-cycle multiplier
//                    undefined -> no multiplier, op 12 is illegal, busy = 0
//
// Ports:
//   Clk, Rst         clock (rising edge), async active-low reset
//   in_valid/ready   input handshake for op, a, b, branch_mode
//   op[3:0]          operation select
//   a, b [WIDTH]     operands; shifts use b[SW-1:0]
//   branch_mode[1:0] 01 BEQ, 10 BNE, others none
//   out_valid/ready  output handshake
//   result [WIDTH]   registered result
//   zero             result == 0
//   pc_src           branch taken
//   illegal          unsupported op
//   busy             multiply in progress
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       branch_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             pc_src,
    output logic             illegal,
    output logic             busy
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_SLTU = 4'd11;
`ifdef ALU_EXEC_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd12;
`endif

    // ---------------------------------------------------------------
    // Single-cycle ALU
    // ---------------------------------------------------------------
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;

    assign shamt = b[SW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  alu_res = a + b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SUB:  alu_res = a - b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_ill = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------
    // Control: decides when the output registers load and with what
    // ---------------------------------------------------------------
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_res;
    logic             load_ill;
    logic [1:0]       load_bm;

`ifdef ALU_EXEC_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;   // multiplicand, shifted left each step
    logic [WIDTH-1:0] mplier_q, mplier_d; // multiplier, LSB consumed each step
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [1:0]       bm_q, bm_d;         // branch_mode captured at accept

    assign in_ready = (state_q == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == S_MUL);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        bm_d     = bm_q;
        load     = 1'b0;
        load_res = alu_res;
        load_ill = alu_ill;
        load_bm  = branch_mode;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_d  = S_MUL;
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        bm_d     = branch_mode;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SW'(1);
                if (cnt_q == SW'(WIDTH-1)) begin
                    // final partial product goes straight into the outputs
                    load     = 1'b1;
                    load_res = acc_d;
                    load_ill = 1'b0;
                    load_bm  = bm_q;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            bm_q     <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            bm_q     <= bm_d;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign busy     = 1'b0;
    assign load     = accept;
    assign load_res = alu_res;
    assign load_ill = alu_ill;
    assign load_bm  = branch_mode;
`endif

    // ---------------------------------------------------------------
    // Output registers
    // ---------------------------------------------------------------
    logic             zero_next;
    logic             pc_next;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             pc_src_q, pc_src_d;
    logic             illegal_q, illegal_d;

    assign zero_next = (load_res == '0);
    assign pc_next   = ((load_bm == 2'b01) && zero_next) ||
                       ((load_bm == 2'b10) && !zero_next);

    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        zero_d      = zero_q;
        pc_src_d    = pc_src_q;
        illegal_d   = illegal_q;
        if (load) begin
            out_valid_d = 1'b1;
            result_d    = load_res;
            zero_d      = zero_next;
            pc_src_d    = pc_next;
            illegal_d   = load_ill;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            pc_src_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            pc_src_q    <= pc_src_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign pc_src    = pc_src_q;
    assign illegal   = illegal_q;

endmodule
